// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing big-endian words into IMEM
//
// Receives a frame of A5, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x (HI, LO), CSUM
// over an 8-bit valid/ready byte interface. Each (HI, LO) pair becomes one
// IMEM write. The CPU is held in reset from the frame start byte until a frame
// whose XOR checksum matches has been received.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   rx_data    in   incoming byte
//   rx_valid   in   rx_data valid
//   rx_ready   out  byte consumed on an edge with rx_valid && rx_ready
//   imem_we    out  one-cycle IMEM write strobe
//   imem_addr  out  IMEM write address
//   imem_wdata out  IMEM write word
//   cpu_rst    out  active-high reset to the CPU core
//   busy       out  frame in progress
//   load_ok    out  one-cycle pulse, frame accepted
//   load_err   out  one-cycle pulse, checksum mismatch
module imem_loader #(
    parameter int im_size = 16,
    parameter int iw_size = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [im_size-1:0] imem_addr,
    output logic [iw_size-1:0] imem_wdata,
    output logic               cpu_rst,
    output logic               busy,
    output logic               load_ok,
    output logic               load_err
);

    localparam logic [7:0] SOF = 8'hA5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DATA_H,
        S_DATA_L,
        S_CSUM,
        S_DONE_OK,
        S_DONE_ERR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_ready_en;
    logic [15:0]          r_addr;
    logic [15:0]          r_cnt;
    logic [7:0]           r_hi;
    logic [7:0]           r_xor;
    logic                 r_we;
    logic [im_size-1:0]   r_waddr;
    logic [iw_size-1:0]   r_wdata;
    logic                 r_cpu_rst;
    logic                 w_accept;
    logic                 w_done;

    // r_ready_en keeps rx_ready low while reset is held and during the
    // reset-release edge, so no byte is ever consumed in a reset cycle.
    assign w_done     = (r_state == S_DONE_OK) || (r_state == S_DONE_ERR);
    assign rx_ready   = r_ready_en && !w_done;
    assign w_accept   = rx_valid && rx_ready;

    assign imem_we    = r_we;
    assign imem_addr  = r_waddr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = (r_state != S_IDLE);
    assign load_ok    = (r_state == S_DONE_OK);
    assign load_err   = (r_state == S_DONE_ERR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_accept && rx_data == SOF) w_next = S_ADDR_H;
            S_ADDR_H:   if (w_accept) w_next = S_ADDR_L;
            S_ADDR_L:   if (w_accept) w_next = S_CNT_H;
            S_CNT_H:    if (w_accept) w_next = S_CNT_L;
            S_CNT_L: begin
                // Count low byte is still on the bus; test the full count here.
                if (w_accept) begin
                    w_next = ({r_cnt[15:8], rx_data} != 16'd0) ? S_DATA_H : S_CSUM;
                end
            end
            S_DATA_H:   if (w_accept) w_next = S_DATA_L;
            S_DATA_L: begin
                if (w_accept) begin
                    w_next = (r_cnt == 16'd1) ? S_CSUM : S_DATA_H;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next = (rx_data == r_xor) ? S_DONE_OK : S_DONE_ERR;
                end
            end
            S_DONE_OK:  w_next = S_IDLE;
            S_DONE_ERR: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready_en <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_xor      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_cpu_rst  <= 1'b1;
        end else begin
            r_ready_en <= 1'b1;
            r_we       <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == SOF) begin
                            r_xor     <= '0;
                            r_cpu_rst <= 1'b1;
                        end
                    end
                    S_ADDR_H: begin
                        r_addr[15:8] <= rx_data;
                        r_xor        <= r_xor ^ rx_data;
                    end
                    S_ADDR_L: begin
                        r_addr[7:0] <= rx_data;
                        r_xor       <= r_xor ^ rx_data;
                    end
                    S_CNT_H: begin
                        r_cnt[15:8] <= rx_data;
                        r_xor       <= r_xor ^ rx_data;
                    end
                    S_CNT_L: begin
                        r_cnt[7:0] <= rx_data;
                        r_xor      <= r_xor ^ rx_data;
                    end
                    S_DATA_H: begin
                        r_hi  <= rx_data;
                        r_xor <= r_xor ^ rx_data;
                    end
                    S_DATA_L: begin
                        // Address wraps naturally at the 16-bit boundary.
                        r_we    <= 1'b1;
                        r_waddr <= r_addr[im_size-1:0];
                        r_wdata <= {r_hi, rx_data};
                        r_addr  <= r_addr + 16'd1;
                        r_cnt   <= r_cnt - 16'd1;
                        r_xor   <= r_xor ^ rx_data;
                    end
                    S_CSUM: begin
                        if (rx_data == r_xor) begin
                            r_cpu_rst <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
